// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: multicycle IF/ID/EX/MEM/WB sequencer for the M_CPU datapath.
// Drives PC/IR/regfile/dmem write enables and the datapath mux/ALU selects.
module mcpu_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       PCWre,
    output logic       IRWre,
    output logic       RegWre,
    output logic       MemWre,
    output logic       ALUSrcB,
    output logic       ExtSel,
    output logic [2:0] ALUOp,
    output logic [1:0] RegDst,
    output logic       MemtoReg,
    output logic       WrRegDSrc,
    output logic [1:0] PCSrc,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        ST_IF   = 4'd0,
        ST_ID   = 4'd1,
        ST_EXA  = 4'd2,
        ST_WBA  = 4'd3,
        ST_EXB  = 4'd4,
        ST_EXM  = 4'd5,
        ST_MEM  = 4'd6,
        ST_WBL  = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_HALT = 6'b111111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    state_t cur, nxt;

    logic is_r, r_add, r_sub, r_and, r_or, r_slt, r_alu, is_jr;
    logic is_addi, is_ori, is_lw, is_sw, is_beq, is_bne;
    logic is_j, is_jal, is_halt, is_br, is_mem, is_imm;
    logic taken;

    assign is_r    = (op == OP_R);
    assign r_add   = is_r && (funct == FN_ADD);
    assign r_sub   = is_r && (funct == FN_SUB);
    assign r_and   = is_r && (funct == FN_AND);
    assign r_or    = is_r && (funct == FN_OR);
    assign r_slt   = is_r && (funct == FN_SLT);
    assign r_alu   = r_add | r_sub | r_and | r_or | r_slt;
    assign is_jr   = is_r && (funct == FN_JR);
    assign is_addi = (op == OP_ADDI);
    assign is_ori  = (op == OP_ORI);
    assign is_lw   = (op == OP_LW);
    assign is_sw   = (op == OP_SW);
    assign is_beq  = (op == OP_BEQ);
    assign is_bne  = (op == OP_BNE);
    assign is_j    = (op == OP_J);
    assign is_jal  = (op == OP_JAL);
    assign is_halt = (op == OP_HALT);
    assign is_br   = is_beq | is_bne;
    assign is_mem  = is_lw | is_sw;
    assign is_imm  = is_addi | is_ori;
    assign taken   = (is_beq && zero) || (is_bne && !zero);

    // Selects decoded once and held from ID until the instruction retires.
    logic [2:0] dec_aluop;
    logic       dec_srcb;
    logic       dec_ext;

    always_comb begin
        dec_aluop = ALU_ADD;
        dec_srcb  = 1'b0;
        dec_ext   = 1'b0;
        unique case (1'b1)
            r_add:   dec_aluop = ALU_ADD;
            r_sub:   dec_aluop = ALU_SUB;
            r_and:   dec_aluop = ALU_AND;
            r_or:    dec_aluop = ALU_OR;
            r_slt:   dec_aluop = ALU_SLT;
            is_addi: begin
                dec_aluop = ALU_ADD;
                dec_srcb  = 1'b1;
                dec_ext   = 1'b1;
            end
            is_ori: begin
                dec_aluop = ALU_OR;
                dec_srcb  = 1'b1;
            end
            is_mem: begin
                dec_aluop = ALU_ADD;
                dec_srcb  = 1'b1;
                dec_ext   = 1'b1;
            end
            is_br: begin
                dec_aluop = ALU_SUB;
                dec_ext   = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cur <= ST_IF;
        else
            cur <= nxt;
    end

    always_comb begin
        nxt       = ST_IF;
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        RegWre    = 1'b0;
        MemWre    = 1'b0;
        ALUSrcB   = 1'b0;
        ExtSel    = 1'b0;
        ALUOp     = 3'b000;
        RegDst    = 2'b00;
        MemtoReg  = 1'b0;
        WrRegDSrc = 1'b0;
        PCSrc     = 2'b00;
        unique case (cur)
            ST_IF: begin
                IRWre = 1'b1;
                nxt   = ST_ID;
            end
            ST_ID: begin
                ALUOp   = dec_aluop;
                ALUSrcB = dec_srcb;
                ExtSel  = dec_ext;
                unique case (1'b1)
                    is_j: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b11;
                    end
                    is_jal: begin
                        PCWre     = 1'b1;
                        PCSrc     = 2'b11;
                        RegWre    = 1'b1;
                        RegDst    = 2'b10;
                        WrRegDSrc = 1'b1;
                    end
                    is_jr: begin
                        PCWre = 1'b1;
                        PCSrc = 2'b10;
                    end
                    is_halt: nxt = ST_HALT;
                    is_br:   nxt = ST_EXB;
                    is_mem:  nxt = ST_EXM;
                    r_alu:   nxt = ST_EXA;
                    is_imm:  nxt = ST_EXA;
                    default: PCWre = 1'b1;
                endcase
            end
            ST_EXA: begin
                ALUOp   = dec_aluop;
                ALUSrcB = dec_srcb;
                ExtSel  = dec_ext;
                nxt     = ST_WBA;
            end
            ST_WBA: begin
                ALUOp   = dec_aluop;
                ALUSrcB = dec_srcb;
                ExtSel  = dec_ext;
                PCWre   = 1'b1;
                RegWre  = 1'b1;
                RegDst  = is_r ? 2'b01 : 2'b00;
            end
            ST_EXB: begin
                ALUOp   = ALU_SUB;
                ALUSrcB = 1'b0;
                ExtSel  = dec_ext;
                PCWre   = 1'b1;
                PCSrc   = taken ? 2'b01 : 2'b00;
            end
            ST_EXM: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                nxt     = ST_MEM;
            end
            ST_MEM: begin
                ALUOp   = ALU_ADD;
                ALUSrcB = 1'b1;
                ExtSel  = 1'b1;
                // Anything but lw retires here so PCWre still fires once.
                if (is_lw) begin
                    nxt = ST_WBL;
                end else begin
                    MemWre = is_sw;
                    PCWre  = 1'b1;
                end
            end
            ST_WBL: begin
                ALUOp    = ALU_ADD;
                ALUSrcB  = 1'b1;
                ExtSel   = 1'b1;
                RegWre   = 1'b1;
                MemtoReg = 1'b1;
                PCWre    = 1'b1;
            end
            ST_HALT: nxt = ST_HALT;
            default: nxt = ST_IF;
        endcase
        if (rst) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            RegWre    = 1'b0;
            MemWre    = 1'b0;
            ALUSrcB   = 1'b0;
            ExtSel    = 1'b0;
            ALUOp     = 3'b000;
            RegDst    = 2'b00;
            MemtoReg  = 1'b0;
            WrRegDSrc = 1'b0;
            PCSrc     = 2'b00;
        end
    end

    assign state = cur;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: directed per-instruction walks of the multicycle controller.
// Tracks every state and write enable cycle by cycle against hand tables.
module tb_mcpu_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       PCWre, IRWre, RegWre, MemWre;
    logic       ALUSrcB, ExtSel, MemtoReg, WrRegDSrc;
    logic [2:0] ALUOp;
    logic [1:0] RegDst, PCSrc;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mcpu_ctrl dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .zero(zero),
        .PCWre(PCWre), .IRWre(IRWre), .RegWre(RegWre), .MemWre(MemWre),
        .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .WrRegDSrc(WrRegDSrc),
        .PCSrc(PCSrc), .state(state)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] ens;
        return {PCWre, IRWre, RegWre, MemWre};
    endfunction

    function automatic logic [10:0] sels;
        return {ALUSrcB, ExtSel, ALUOp, RegDst, MemtoReg, WrRegDSrc, PCSrc};
    endfunction

    // Starts in IF, stops while sampling the instruction's final state.
    task automatic run(input string nm, input logic [5:0] o,
                       input logic [5:0] f, input logic z, input int n,
                       input logic [23:0] seq, input logic rw,
                       input logic mw);
        op = o;
        funct = f;
        zero = z;
        #1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) step();
            chk($sformatf("%s_st%0d", nm, i), 32'(state), 32'(seq[4*i +: 4]));
            chk($sformatf("%s_en%0d", nm, i), 32'(ens()),
                32'({i == n - 1, i == 0, rw && i == n - 1, mw && i == n - 1}));
        end
    endtask

    initial begin
        rst = 1'b1;
        op = 6'd0;
        funct = 6'd0;
        zero = 1'b0;
        step();
        step();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_en", 32'(ens()), 32'd0);
        chk("rst_sel", 32'(sels()), 32'd0);
        rst = 1'b0;
        #1;

        run("add", 6'b000000, 6'b100000, 1'b0, 4, 24'h3210, 1'b1, 1'b0);
        chk("add_regdst", 32'(RegDst), 32'd1);
        chk("add_aluop", 32'(ALUOp), 32'd0);
        chk("add_pcsrc", 32'(PCSrc), 32'd0);
        step();

        run("sub", 6'b000000, 6'b100010, 1'b0, 4, 24'h3210, 1'b1, 1'b0);
        chk("sub_aluop", 32'(ALUOp), 32'd1);
        chk("sub_srcb", 32'(ALUSrcB), 32'd0);
        step();

        run("slt", 6'b000000, 6'b101010, 1'b0, 4, 24'h3210, 1'b1, 1'b0);
        chk("slt_aluop", 32'(ALUOp), 32'd4);
        step();

        run("ori", 6'b001101, 6'b000000, 1'b0, 4, 24'h3210, 1'b1, 1'b0);
        chk("ori_aluop", 32'(ALUOp), 32'd3);
        chk("ori_srcb", 32'(ALUSrcB), 32'd1);
        chk("ori_ext", 32'(ExtSel), 32'd0);
        chk("ori_regdst", 32'(RegDst), 32'd0);
        step();

        run("addi", 6'b001000, 6'b000000, 1'b0, 4, 24'h3210, 1'b1, 1'b0);
        chk("addi_aluop", 32'(ALUOp), 32'd0);
        chk("addi_ext", 32'(ExtSel), 32'd1);
        chk("addi_regdst", 32'(RegDst), 32'd0);
        step();

        run("sw", 6'b101011, 6'b000000, 1'b0, 4, 24'h6510, 1'b0, 1'b1);
        chk("sw_srcb", 32'(ALUSrcB), 32'd1);
        chk("sw_ext", 32'(ExtSel), 32'd1);
        step();

        run("lw", 6'b100011, 6'b000000, 1'b0, 5, 24'h76510, 1'b1, 1'b0);
        chk("lw_memtoreg", 32'(MemtoReg), 32'd1);
        chk("lw_regdst", 32'(RegDst), 32'd0);
        step();

        run("beq1", 6'b000100, 6'b000000, 1'b1, 3, 24'h410, 1'b0, 1'b0);
        chk("beq1_pcsrc", 32'(PCSrc), 32'd1);
        chk("beq1_aluop", 32'(ALUOp), 32'd1);
        step();
        run("beq0", 6'b000100, 6'b000000, 1'b0, 3, 24'h410, 1'b0, 1'b0);
        chk("beq0_pcsrc", 32'(PCSrc), 32'd0);
        step();
        run("bne0", 6'b000101, 6'b000000, 1'b0, 3, 24'h410, 1'b0, 1'b0);
        chk("bne0_pcsrc", 32'(PCSrc), 32'd1);
        step();
        run("bne1", 6'b000101, 6'b000000, 1'b1, 3, 24'h410, 1'b0, 1'b0);
        chk("bne1_pcsrc", 32'(PCSrc), 32'd0);
        step();

        run("j", 6'b000010, 6'b000000, 1'b0, 2, 24'h10, 1'b0, 1'b0);
        chk("j_pcsrc", 32'(PCSrc), 32'd3);
        chk("j_wrsrc", 32'(WrRegDSrc), 32'd0);
        step();
        run("jal", 6'b000011, 6'b000000, 1'b0, 2, 24'h10, 1'b1, 1'b0);
        chk("jal_pcsrc", 32'(PCSrc), 32'd3);
        chk("jal_regdst", 32'(RegDst), 32'd2);
        chk("jal_wrsrc", 32'(WrRegDSrc), 32'd1);
        step();
        run("jr", 6'b000000, 6'b001000, 1'b0, 2, 24'h10, 1'b0, 1'b0);
        chk("jr_pcsrc", 32'(PCSrc), 32'd2);
        step();

        run("nop", 6'b010000, 6'b000000, 1'b0, 2, 24'h10, 1'b0, 1'b0);
        chk("nop_pcsrc", 32'(PCSrc), 32'd0);
        step();
        run("rnop", 6'b000000, 6'b000001, 1'b0, 2, 24'h10, 1'b0, 1'b0);
        chk("rnop_pcsrc", 32'(PCSrc), 32'd0);
        step();

        run("lwr", 6'b100011, 6'b000000, 1'b0, 5, 24'h76510, 1'b1, 1'b0);
        rst = 1'b1;
        #1;
        chk("mid_rst_state", 32'(state), 32'd0);
        chk("mid_rst_en", 32'(ens()), 32'd0);
        chk("mid_rst_sel", 32'(sels()), 32'd0);
        step();
        chk("mid_rst_hold", 32'(state), 32'd0);
        chk("mid_rst_hold_en", 32'(ens()), 32'd0);
        rst = 1'b0;
        run("post_rst", 6'b000000, 6'b100000, 1'b0, 4, 24'h3210, 1'b1, 1'b0);
        step();

        op = 6'b111111;
        funct = 6'd0;
        #1;
        chk("halt_if", 32'(state), 32'd0);
        step();
        chk("halt_id", 32'(state), 32'd1);
        chk("halt_id_en", 32'(ens()), 32'd0);
        for (int i = 0; i < 20; i++) begin
            step();
            chk($sformatf("halt_st%0d", i), 32'(state), 32'd8);
            chk($sformatf("halt_en%0d", i), 32'(ens()), 32'd0);
        end
        rst = 1'b1;
        #1;
        chk("halt_rst", 32'(state), 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("halt_exit_st", 32'(state), 32'd0);
        chk("halt_exit_en", 32'(ens()), 32'b0100);
        step();
        chk("halt_exit_id", 32'(state), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
